// File: rtl/minibyte_pkg.sv
// minibyte_pkg: arbiter state encoding, default timing constants and counter sizing.
package minibyte_pkg;
  typedef enum logic [1:0] {
    CPU   = 2'd0,
    DRAIN = 2'd1,
    DBG   = 2'd2,
    RET   = 2'd3
  } arb_state_e;
  localparam int CPU_MIN_CYCLES_DEF = 4;
  localparam int DBG_MAX_BURST_DEF = 8;
  // Wide enough to hold the larger limit; never below one bit so zero limits still build.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = a > b ? a : b;
    return m < 1 ? 1 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/minibyte_satcnt.sv
// minibyte_satcnt: up-counter that stops at LIMIT, with synchronous clear.
module minibyte_satcnt #(
  parameter int W = 4,
  parameter int LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  localparam logic [W-1:0] LIM = W'(LIMIT);
  assign sat = cnt >= LIM;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !sat) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/minibyte_mem_arb.sv
// minibyte_mem_arb: shares one memory bus between a CPU and a debug master by freezing the CPU.
// Define MINIBYTE_ARB_STATS_EN to enable the saturating debug-access counter on dbg_count_out.
module minibyte_mem_arb
  import minibyte_pkg::*;
#(
  parameter int CPU_MIN_CYCLES = CPU_MIN_CYCLES_DEF,
  parameter int DBG_MAX_BURST = DBG_MAX_BURST_DEF
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] cpu_addr_in,
  input  logic [7:0] cpu_data_in,
  input  logic       cpu_we_in,
  input  logic       cpu_drive_in,
  output logic       cpu_ce_out,
  input  logic       dbg_req_in,
  input  logic [7:0] dbg_addr_in,
  input  logic [7:0] dbg_data_in,
  input  logic       dbg_we_in,
  output logic       dbg_gnt_out,
  output logic       dbg_ack_out,
  output logic [7:0] dbg_rdata_out,
  output logic [7:0] dbg_count_out,
  output logic [7:0] mem_addr_out,
  output logic [7:0] mem_data_out,
  output logic       mem_we_out,
  output logic       mem_drive_out,
  input  logic [7:0] mem_data_in
);
  localparam int CW = cnt_width(CPU_MIN_CYCLES, DBG_MAX_BURST);
  // Values in the cycle that completes the window / burst, so the edge closing it switches state.
  localparam logic [CW-1:0] WIN_LAST = CW'(CPU_MIN_CYCLES == 0 ? 0 : CPU_MIN_CYCLES - 1);
  localparam logic [CW-1:0] BUR_LAST = CW'(DBG_MAX_BURST == 0 ? 0 : DBG_MAX_BURST - 1);
  arb_state_e state, state_n;
  logic [CW-1:0] win_cnt, bur_cnt;
  logic win_sat, bur_sat, in_cpu, in_dbg, in_ret, access, dbg_wr, go, done;
  assign in_cpu = state == CPU;
  assign in_dbg = state == DBG;
  assign in_ret = state == RET;
  assign access = in_dbg && dbg_req_in;
  assign dbg_wr = access && dbg_we_in;
  assign go = dbg_req_in && (win_sat || win_cnt == WIN_LAST);
  assign done = !dbg_req_in || bur_sat || bur_cnt == BUR_LAST;
  always_comb
    state_n = in_cpu ? (go ? DRAIN : CPU) :
              state == DRAIN ? DBG :
              in_dbg ? (done ? RET : DBG) : CPU;
  minibyte_satcnt #(.W(CW), .LIMIT(CPU_MIN_CYCLES)) u_win (
    .clk(clk_in), .rst(rst_in), .clr(in_ret), .inc(in_cpu), .cnt(win_cnt), .sat(win_sat)
  );
  minibyte_satcnt #(.W(CW), .LIMIT(DBG_MAX_BURST)) u_bur (
    .clk(clk_in), .rst(rst_in), .clr(in_ret), .inc(access), .cnt(bur_cnt), .sat(bur_sat)
  );
`ifdef MINIBYTE_ARB_STATS_EN
  logic stats_sat;
  minibyte_satcnt #(.W(8), .LIMIT(255)) u_stats (
    .clk(clk_in), .rst(rst_in), .clr(1'b0), .inc(access && !stats_sat), .cnt(dbg_count_out),
    .sat(stats_sat)
  );
`else
  assign dbg_count_out = 8'h00;
`endif
  assign cpu_ce_out = in_cpu;
  assign dbg_gnt_out = in_dbg;
  assign mem_addr_out = in_dbg ? dbg_addr_in : cpu_addr_in;
  assign mem_data_out = in_dbg ? dbg_data_in : cpu_data_in;
  assign mem_we_out = in_cpu ? cpu_we_in : dbg_wr;
  assign mem_drive_out = in_cpu ? cpu_drive_in : dbg_wr;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state <= CPU;
      dbg_ack_out <= 1'b0;
      dbg_rdata_out <= 8'h00;
    end else begin
      state <= state_n;
      dbg_ack_out <= access;
      if (access && !dbg_we_in) dbg_rdata_out <= mem_data_in;
    end
endmodule

// File: tb/tb_minibyte_mem_arb.sv
// tb_minibyte_mem_arb: directed checks of ownership timing, debug read/write, bursts, reset and stats.
module tb_minibyte_mem_arb;
`ifdef MINIBYTE_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk_in = 1'b0, rst_in = 1'b1;
  logic [7:0] cpu_addr_in = '0, cpu_data_in = '0, dbg_addr_in = '0, dbg_data_in = '0;
  logic [7:0] mem_data_in = '0;
  logic cpu_we_in = 1'b0, cpu_drive_in = 1'b0, dbg_req_in = 1'b0, dbg_we_in = 1'b0;
  logic cpu_ce_out, dbg_gnt_out, dbg_ack_out, mem_we_out, mem_drive_out;
  logic [7:0] dbg_rdata_out, dbg_count_out, mem_addr_out, mem_data_out;
  int errors = 0, checks = 0;
  minibyte_mem_arb dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
    .cpu_we_in(cpu_we_in), .cpu_drive_in(cpu_drive_in), .cpu_ce_out(cpu_ce_out),
    .dbg_req_in(dbg_req_in), .dbg_addr_in(dbg_addr_in), .dbg_data_in(dbg_data_in),
    .dbg_we_in(dbg_we_in), .dbg_gnt_out(dbg_gnt_out), .dbg_ack_out(dbg_ack_out),
    .dbg_rdata_out(dbg_rdata_out), .dbg_count_out(dbg_count_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_we_out(mem_we_out), .mem_drive_out(mem_drive_out), .mem_data_in(mem_data_in)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask
  task automatic do_reset();
    rst_in = 1'b1;
    dbg_req_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask
  initial begin
    int p, q, acks, issued;
    logic eg, ec, ea;
    // Reset values
    do_reset();
    rst_in = 1'b1;
    #1;
    chk("rst_ce", cpu_ce_out, 1);
    chk("rst_gnt", dbg_gnt_out, 0);
    chk("rst_ack", dbg_ack_out, 0);
    chk("rst_rdata", dbg_rdata_out, 8'h00);
    chk("rst_count", dbg_count_out, 8'h00);
    @(negedge clk_in);
    rst_in = 1'b0;
    // Held request: CPU cycles 1-4, DRAIN cycle 5, grant cycle 6; single read of 0x10
    dbg_req_in = 1'b1;
    dbg_addr_in = 8'h10;
    mem_data_in = 8'hA5;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("win_ce_c%0d", i), cpu_ce_out, 1);
      chk($sformatf("win_gnt_c%0d", i), dbg_gnt_out, 0);
      tick();
    end
    chk("drain_ce", cpu_ce_out, 0);
    chk("drain_gnt", dbg_gnt_out, 0);
    tick();
    chk("rd_gnt", dbg_gnt_out, 1);
    chk("rd_addr", mem_addr_out, 8'h10);
    chk("rd_we", mem_we_out, 0);
    @(negedge clk_in);
    dbg_req_in = 1'b0;
    #1;
    chk("rd_ack", dbg_ack_out, 1);
    chk("rd_rdata", dbg_rdata_out, 8'hA5);
    chk("rd_count", dbg_count_out, STATS ? 8'd1 : 8'd0);
    tick();
    chk("ret_ce", cpu_ce_out, 0);
    chk("ret_ack", dbg_ack_out, 0);
    @(negedge clk_in);
    cpu_addr_in = 8'h55;
    cpu_data_in = 8'h66;
    cpu_we_in = 1'b1;
    cpu_drive_in = 1'b1;
    #1;
    chk("cpu_ce", cpu_ce_out, 1);
    chk("cpu_addr", mem_addr_out, 8'h55);
    chk("cpu_data", mem_data_out, 8'h66);
    chk("cpu_we", mem_we_out, 1);
    chk("cpu_drive", mem_drive_out, 1);
    // Debug write 0x3C to 0xFE; CPU write strobe held high must not leak in DRAIN/RET
    dbg_req_in = 1'b1;
    dbg_we_in = 1'b1;
    dbg_addr_in = 8'hFE;
    dbg_data_in = 8'h3C;
    repeat (4) tick();
    chk("wdrain_ce", cpu_ce_out, 0);
    chk("wdrain_we", mem_we_out, 0);
    chk("wdrain_drive", mem_drive_out, 0);
    chk("wdrain_addr", mem_addr_out, 8'h55);
    chk("wdrain_data", mem_data_out, 8'h66);
    tick();
    chk("wr_gnt", dbg_gnt_out, 1);
    chk("wr_we", mem_we_out, 1);
    chk("wr_drive", mem_drive_out, 1);
    chk("wr_addr", mem_addr_out, 8'hFE);
    chk("wr_data", mem_data_out, 8'h3C);
    @(negedge clk_in);
    dbg_req_in = 1'b0;
    #1;
    chk("wr_ack", dbg_ack_out, 1);
    chk("wr_we_off", mem_we_out, 0);
    chk("wr_rdata_hold", dbg_rdata_out, 8'hA5);
    chk("wr_count", dbg_count_out, STATS ? 8'd2 : 8'd0);
    @(negedge clk_in);
    cpu_we_in = 1'b0;
    #1;
    chk("wret_we0", mem_we_out, 0);
    cpu_we_in = 1'b1;
    #1;
    chk("wret_we1", mem_we_out, 0);
    chk("wret_ce", cpu_ce_out, 0);
    tick();
    chk("wcpu_we", mem_we_out, 1);
    cpu_we_in = 1'b0;
    cpu_drive_in = 1'b0;
    // 20 accesses held: period of 4 CPU, DRAIN, 8 DBG, RET
    do_reset();
    dbg_we_in = 1'b0;
    acks = 0;
    for (int i = 0; i <= 39; i++) begin
      dbg_req_in = i <= 36;
      #1;
      p = i % 14;
      q = (i + 13) % 14;
      eg = i <= 37 && p >= 5 && p <= 12;
      ec = i <= 37 ? p < 4 : i == 39;
      ea = i >= 1 && i <= 37 && q >= 5 && q <= 12;
      if (dbg_ack_out) acks++;
      chk($sformatf("b20_gnt_%0d", i), dbg_gnt_out, eg);
      chk($sformatf("b20_ce_%0d", i), cpu_ce_out, ec);
      chk($sformatf("b20_ack_%0d", i), dbg_ack_out, ea);
      @(negedge clk_in);
    end
    chk("b20_total", acks, 20);
    // Reset pulsed during the third access of a burst
    do_reset();
    dbg_req_in = 1'b1;
    repeat (7) @(negedge clk_in);
    #1;
    chk("ar_gnt_pre", dbg_gnt_out, 1);
    chk("ar_ack_pre", dbg_ack_out, 1);
    rst_in = 1'b1;
    #1;
    chk("ar_ce", cpu_ce_out, 1);
    chk("ar_gnt", dbg_gnt_out, 0);
    chk("ar_ack", dbg_ack_out, 0);
    chk("ar_rdata", dbg_rdata_out, 8'h00);
    chk("ar_count", dbg_count_out, 8'h00);
    @(negedge clk_in);
    rst_in = 1'b0;
    dbg_req_in = 1'b0;
    #1;
    chk("ar_rel_ack", dbg_ack_out, 0);
    chk("ar_rel_ce", cpu_ce_out, 1);
    tick();
    chk("ar_rel_ack2", dbg_ack_out, 0);
    chk("ar_rel_ce2", cpu_ce_out, 1);
    // 300 accesses: stats counter saturates at 0xFF
    do_reset();
    acks = 0;
    issued = 0;
    for (int i = 0; i < 1200 && acks < 300; i++) begin
      dbg_req_in = issued < 300;
      #1;
      if (dbg_gnt_out && dbg_req_in) issued++;
      if (dbg_ack_out) acks++;
      chk("st_count", dbg_count_out, STATS ? (acks > 255 ? 255 : acks) : 0);
      @(negedge clk_in);
    end
    dbg_req_in = 1'b0;
    chk("st_acks", acks, 300);
    repeat (20) tick();
    chk("st_final", dbg_count_out, STATS ? 8'hFF : 8'h00);
    chk("st_ce", cpu_ce_out, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/minibyte_mem_arb.md
MINIBYTE_MEM_ARB -- requirements
Module: minibyte_mem_arb

Interface
REQ-001 SHALL have parameter CPU_MIN_CYCLES, default 4: minimum number of CPU-owned cycles between debug bursts.
REQ-002 SHALL have parameter DBG_MAX_BURST, default 8: maximum number of debug accesses per grant.
REQ-003 SHALL have these ports:
- clk_in  in  1  clock; rising-edge triggered.
- rst_in  in  1  reset; asynchronous, active-high.
- cpu_addr_in / cpu_data_in  in  8 / 8  CPU address and write data.
- cpu_we_in / cpu_drive_in  in  1 / 1  CPU write strobe and bus drive.
- cpu_ce_out  out  1  CPU clock enable; low freezes the CPU.
- dbg_req_in  in  1  debug master access request, level.
- dbg_addr_in / dbg_data_in  in  8 / 8  debug address and write data.
- dbg_we_in  in  1  debug write (1) or read (0).
- dbg_gnt_out  out  1  debug master owns the bus.
- dbg_ack_out  out  1  one-cycle pulse: one debug access completed.
- dbg_rdata_out  out  8  read data, valid while dbg_ack_out is high.
- dbg_count_out  out  8  saturating count of debug accesses.
- mem_addr_out / mem_data_out  out  8 / 8  memory address and write data.
- mem_we_out / mem_drive_out  out  1 / 1  memory write strobe and bus drive.
- mem_data_in  in  8  memory read data.

Function
REQ-004 SHALL implement a 4-state FSM: CPU, DRAIN, DBG, RET.
REQ-005 In CPU state:
- mem_* SHALL equal the cpu_* inputs combinationally.
- cpu_ce_out=1 and dbg_gnt_out=0.
- The window counter SHALL increment each cycle, saturating at CPU_MIN_CYCLES.
REQ-006 CPU->DRAIN SHALL occur at a clock edge only when dbg_req_in=1 and the window counter is at least CPU_MIN_CYCLES; the CPU completes that cycle unaffected.
REQ-007 In DRAIN and RET:
- cpu_ce_out=0, mem_we_out=0, mem_drive_out=0, mem_addr_out=cpu_addr_in, mem_data_out=cpu_data_in.
- Each state SHALL last exactly one cycle: DRAIN->DBG, RET->CPU.
REQ-008 In DBG, dbg_gnt_out=1, cpu_ce_out=0, mem_addr_out=dbg_addr_in and mem_data_out=dbg_data_in.
REQ-009 In DBG, mem_we_out=dbg_req_in&dbg_we_in and mem_drive_out=dbg_req_in&dbg_we_in.
REQ-010 Each DBG cycle with dbg_req_in=1 is one access. At its closing edge:
- dbg_rdata_out SHALL load mem_data_in on reads and hold its value on writes.
- dbg_ack_out SHALL be 1 for the next cycle only.
- The burst counter SHALL increment.
REQ-011 DBG->RET SHALL occur when dbg_req_in=0 (no access that cycle) or when the access just taken makes the burst count equal DBG_MAX_BURST.
REQ-012 On RET->CPU, the window counter and burst counter SHALL clear to 0.
REQ-013 dbg_req_in dropping in DRAIN SHALL NOT abort the sequence: DBG is entered and immediately exits per REQ-011 with zero accesses.
REQ-014 A request held continuously SHALL alternate:
- DBG_MAX_BURST accesses;
- RET, 1 cycle;
- CPU_MIN_CYCLES CPU cycles;
- DRAIN, 1 cycle;
- the next burst.
REQ-015 Counter widths SHALL be $clog2(max(CPU_MIN_CYCLES,DBG_MAX_BURST)+1), with no wrap-around.
REQ-016 CPU_MIN_CYCLES=0 SHALL permit a grant on the first CPU-state cycle after reset or RET.

Reset
REQ-017 While rst_in=1, the block SHALL hold:
- state=CPU; window counter=0; burst counter=0;
- cpu_ce_out=1, dbg_gnt_out=0, dbg_ack_out=0, dbg_rdata_out=0x00, dbg_count_out=0x00.
REQ-018 Reset asserted mid-burst SHALL abort the access immediately, with no ack and the CPU owning the bus on release.

Configuration
REQ-019 With MINIBYTE_ARB_STATS_EN defined, dbg_count_out SHALL increment on each access per REQ-010 and saturate at 0xFF.
REQ-020 Without MINIBYTE_ARB_STATS_EN, dbg_count_out SHALL be constant 0x00 and no counter flops SHALL be inferred.

Structure
REQ-021 Shared package minibyte_pkg SHALL hold:
- the arbiter state enum (CPU=2'd0, DRAIN=2'd1, DBG=2'd2, RET=2'd3);
- the default CPU_MIN_CYCLES and DBG_MAX_BURST constants.
REQ-022 The window, burst and stats counters SHALL each be an instance of sub-module minibyte_satcnt: parameterised width and limit, with clear, increment and saturated-flag ports.

Verification
REQ-023 Reset, then hold dbg_req_in=1:
- cpu_ce_out=1 in cycles 1-4, DRAIN in cycle 5, dbg_gnt_out=1 from cycle 6.
REQ-024 Debug read of addr 0x10 with memory returning 0xA5:
- mem_addr_out=0x10 and mem_we_out=0 in the DBG cycle.
- Next cycle: dbg_ack_out=1 and dbg_rdata_out=0xA5.
REQ-025 Request held for 20 accesses with defaults:
- 8 acks, RET, 4 CPU cycles, DRAIN, 8 acks, RET, 4 CPU cycles, DRAIN, 4 acks.
REQ-026 Debug write 0x3C to 0xFE:
- mem_we_out=1, mem_drive_out=1, mem_data_out=0x3C for exactly one cycle.
- cpu_we_in toggling during DRAIN/RET never reaches mem_we_out.
REQ-027 rst_in pulsed during the 3rd access of a burst:
- Outputs take reset values asynchronously; no ack follows.
- With MINIBYTE_ARB_STATS_EN defined, dbg_count_out=0x00.
REQ-028 With MINIBYTE_ARB_STATS_EN defined, perform 300 accesses:
- dbg_count_out=0xFF, stable after saturation.
- Without the macro, dbg_count_out stays 0x00.
